sccb_init_sequencer: RTL and testbench

Parametrised camera register-init sequencer. It walks an external table ROM of {opcode, register, value} entries and issues one register transaction per entry to the I2C/SCCB transaction FSM. Supported entry types: plain write, write-with-readback-verify, programmable delay, and end marker. Adds bounded retry, error codes and a restartable start/done handshake. Sits between the settings ROM and the I2C control FSM in the camera control top.

---
 rtl/camera_init_pkg.sv | 53 +++++
 rtl/init_delay_timer.sv | 33 +++
 rtl/sccb_init_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_sccb_init_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_init_pkg.sv
// Shared types for the camera register-init sequencer.
//   opcode_e  : table entry opcodes
//   state_e   : sequencer FSM states
//   ERR_*     : err_code_o values
//   entry_*() : field extraction from a zero-extended table entry {op, reg, val}
package camera_init_pkg;

  typedef enum logic [1:0] {
    OP_WRITE        = 2'b00,
    OP_WRITE_VERIFY = 2'b01,
    OP_DELAY        = 2'b10,
    OP_END          = 2'b11
  } opcode_e;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_ISSUE_WR, ST_WAIT_WR, ST_ISSUE_RD,
    ST_WAIT_RD, ST_COMPARE, ST_DELAY, ST_DONE, ST_FAIL
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_NACK     = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;
  localparam logic [1:0] ERR_OVERRUN  = 2'd3;

  // Widest supported entry: 2-bit op, 16-bit reg, 16-bit val.
  localparam int unsigned ENTRY_MAX_W = 34;
  typedef logic [ENTRY_MAX_W-1:0] entry_t;

  function automatic opcode_e entry_op(input entry_t e, input int unsigned reg_w,
                                       input int unsigned val_w);
    entry_t s;
    s = e >> (reg_w + val_w);
    return opcode_e'(s[1:0]);
  endfunction

  function automatic logic [15:0] entry_reg(input entry_t e, input int unsigned reg_w,
                                            input int unsigned val_w);
    entry_t      s;
    logic [15:0] m;
    s = e >> val_w;
    m = '1;
    m = m >> (16 - reg_w);
    return s[15:0] & m;
  endfunction

  function automatic logic [15:0] entry_val(input entry_t e, input int unsigned val_w);
    logic [15:0] m;
    m = '1;
    m = m >> (16 - val_w);
    return e[15:0] & m;
  endfunction

endpackage

// File: rtl/init_delay_timer.sv
// Down-counter for DELAY table entries.
//   load    : capture count (ticks) and start timing
//   count   : delay in ticks of TICK_CYCLES clock cycles
//   expired : high once count*TICK_CYCLES cycles have elapsed since load
module init_delay_timer #(
  parameter int unsigned VAL_W       = 8,
  parameter int unsigned TICK_CYCLES = 27000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             load,
  input  logic [VAL_W-1:0] count,
  output logic             expired
);

  localparam int unsigned CNT_W = VAL_W + $clog2(TICK_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_load_val;

  // Loaded with N-1 so that the waiting state lasts exactly N cycles.
  assign w_load_val = (count == '0) ? '0
                    : CNT_W'(count) * CNT_W'(TICK_CYCLES) - CNT_W'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)         r_cnt <= '0;
    else if (load)          r_cnt <= w_load_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - CNT_W'(1);
  end

  assign expired = (r_cnt == '0) && !load;

endmodule

// File: rtl/sccb_init_sequencer.sv
// Camera register-init sequencer: walks a {op, reg, val} table ROM and issues
// one SCCB/I2C transaction per entry, with readback verify, delays, bounded
// retry and error reporting.
//   sys_clk/sys_rst_n        : clock, async active-low reset
//   start_i                  : start pulse (ignored while busy)
//   rom_addr_o/rom_data_i    : table ROM port, 1-cycle read latency
//   txn_*                    : transaction request/response to the bus FSM
//   busy_o/done_o/error_o    : sequence status
//   err_code_o/err_addr_o    : failure cause and failing entry address
module sccb_init_sequencer
  import camera_init_pkg::*;
#(
  parameter int unsigned      REG_W       = 8,
  parameter int unsigned      VAL_W       = 8,
  parameter int unsigned      ROM_AW      = 8,
  parameter int unsigned      TICK_CYCLES = 27000,
  parameter int unsigned      MAX_RETRY   = 3,
  parameter logic [VAL_W-1:0] VERIFY_MASK = '1
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   start_i,
  output logic [ROM_AW-1:0]      rom_addr_o,
  input  logic [2+REG_W+VAL_W-1:0] rom_data_i,
  output logic                   txn_valid_o,
  input  logic                   txn_ready_i,
  output logic                   txn_write_o,
  output logic [REG_W-1:0]       txn_reg_o,
  output logic [VAL_W-1:0]       txn_wdata_o,
  input  logic                   txn_done_i,
  input  logic                   txn_err_i,
  input  logic [VAL_W-1:0]       txn_rdata_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [1:0]             err_code_o,
  output logic [ROM_AW-1:0]      err_addr_o
);

  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e             r_state, w_state_nxt;
  logic [ROM_AW-1:0]  r_addr, r_err_addr;
  logic [RETRY_W-1:0] r_retry;
  opcode_e            r_op;
  logic [REG_W-1:0]   r_reg;
  logic [VAL_W-1:0]   r_val, r_rdata;
  logic [1:0]         r_err_code, w_fail_code;

  entry_t             w_entry;
  opcode_e            w_op;
  logic [REG_W-1:0]   w_reg;
  logic [VAL_W-1:0]   w_val;
  logic               w_start, w_advance, w_retry, w_can_retry, w_last_addr;
  logic               w_mismatch, w_expired, w_timer_load;

  assign w_entry     = entry_t'(rom_data_i);
  assign w_op        = entry_op(w_entry, REG_W, VAL_W);
  assign w_reg       = REG_W'(entry_reg(w_entry, REG_W, VAL_W));
  assign w_val       = VAL_W'(entry_val(w_entry, VAL_W));
  assign w_last_addr = (r_addr == '1);
  assign w_can_retry = (r_retry < RETRY_W'(MAX_RETRY));
  assign w_mismatch  = ((r_rdata ^ r_val) & VERIFY_MASK) != '0;
  assign w_timer_load = (r_state == ST_DECODE) && (w_op == OP_DELAY);

  init_delay_timer #(
    .VAL_W       (VAL_W),
    .TICK_CYCLES (TICK_CYCLES)
  ) u_delay (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (w_timer_load),
    .count     (w_val),
    .expired   (w_expired)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Per-state decisions raise advance/retry; the common next-entry and retry
  // resolution is applied once after the case.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_advance   = 1'b0;
    w_retry     = 1'b0;
    w_fail_code = ERR_NONE;
    case (r_state)
      ST_IDLE, ST_DONE, ST_FAIL: if (start_i) begin
        w_start     = 1'b1;
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH:  w_state_nxt = ST_DECODE;
      ST_DECODE: case (w_op)
        OP_WRITE, OP_WRITE_VERIFY: w_state_nxt = ST_ISSUE_WR;
        OP_DELAY: if (w_val == '0) w_advance = 1'b1;
                  else             w_state_nxt = ST_DELAY;
        default:  w_state_nxt = ST_DONE;
      endcase
      ST_ISSUE_WR: if (txn_ready_i) w_state_nxt = ST_WAIT_WR;
      ST_WAIT_WR: if (txn_done_i) begin
        if (txn_err_i) begin
          w_retry     = 1'b1;
          w_fail_code = ERR_NACK;
        end else if (r_op == OP_WRITE_VERIFY) w_state_nxt = ST_ISSUE_RD;
        else                                  w_advance   = 1'b1;
      end
      ST_ISSUE_RD: if (txn_ready_i) w_state_nxt = ST_WAIT_RD;
      ST_WAIT_RD: if (txn_done_i) begin
        if (txn_err_i) begin
          w_retry     = 1'b1;
          w_fail_code = ERR_NACK;
        end else w_state_nxt = ST_COMPARE;
      end
      ST_COMPARE: if (w_mismatch) begin
        w_retry     = 1'b1;
        w_fail_code = ERR_MISMATCH;
      end else w_advance = 1'b1;
      ST_DELAY: if (w_expired) w_advance = 1'b1;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_advance) begin
      if (w_last_addr) begin
        w_state_nxt = ST_FAIL;
        w_fail_code = ERR_OVERRUN;
      end else begin
        w_state_nxt = ST_FETCH;
      end
    end
    if (w_retry) w_state_nxt = w_can_retry ? ST_ISSUE_WR : ST_FAIL;
  end

  always_comb begin
    txn_valid_o = (r_state == ST_ISSUE_WR) || (r_state == ST_ISSUE_RD);
    txn_write_o = (r_state == ST_ISSUE_WR) || (r_state == ST_WAIT_WR);
    busy_o      = !((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_FAIL));
    done_o      = (r_state == ST_DONE);
    error_o     = (r_state == ST_FAIL);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_addr     <= '0;
      r_retry    <= '0;
      r_op       <= OP_WRITE;
      r_reg      <= '0;
      r_val      <= '0;
      r_rdata    <= '0;
      r_err_code <= ERR_NONE;
      r_err_addr <= '0;
    end else begin
      if (w_start) begin
        r_addr     <= '0;
        r_retry    <= '0;
        r_err_code <= ERR_NONE;
        r_err_addr <= '0;
      end
      if (r_state == ST_DECODE) begin
        r_op  <= w_op;
        r_reg <= w_reg;
        r_val <= w_val;
      end
      if ((r_state == ST_WAIT_RD) && txn_done_i) r_rdata <= txn_rdata_i;
      if (w_advance && !w_last_addr) begin
        r_addr  <= r_addr + ROM_AW'(1);
        r_retry <= '0;
      end
      if (w_retry && w_can_retry) r_retry <= r_retry + RETRY_W'(1);
      if ((w_state_nxt == ST_FAIL) && (r_state != ST_FAIL)) begin
        r_err_code <= w_fail_code;
        r_err_addr <= r_addr;
      end
    end
  end

  assign rom_addr_o  = r_addr;
  assign txn_reg_o   = r_reg;
  assign txn_wdata_o = r_val;
  assign err_code_o  = r_err_code;
  assign err_addr_o  = r_err_addr;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
module tb_sccb_init_sequencer;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  rom_addr_o;
  logic [17:0] rom_data_i = '0;
  logic        txn_valid_o, txn_write_o;
  logic        txn_ready_i = 1'b1;
  logic [7:0]  txn_reg_o, txn_wdata_o;
  logic        txn_done_i = 1'b0, txn_err_i = 1'b0;
  logic [7:0]  txn_rdata_i = '0;
  logic        busy_o, done_o, error_o;
  logic [1:0]  err_code_o, err_addr_o;

  sccb_init_sequencer #(
    .REG_W(8), .VAL_W(8), .ROM_AW(2), .TICK_CYCLES(10), .MAX_RETRY(3), .VERIFY_MASK(8'hFF)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start_i(start_i),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .txn_valid_o(txn_valid_o), .txn_ready_i(txn_ready_i), .txn_write_o(txn_write_o),
    .txn_reg_o(txn_reg_o), .txn_wdata_o(txn_wdata_o), .txn_done_i(txn_done_i),
    .txn_err_i(txn_err_i), .txn_rdata_i(txn_rdata_i), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .err_code_o(err_code_o), .err_addr_o(err_addr_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { logic wr; logic [7:0] rg; logic [7:0] dt; int unsigned cy; } txn_t;
  typedef struct { logic err; logic [7:0] rdata; } rsp_t;

  logic [17:0] rom [4];
  txn_t        exp_q[$];
  txn_t        obs_q[$];
  rsp_t        rsp_q[$];
  int unsigned done_cyc_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge sys_clk) rom_data_i <= rom[rom_addr_o];
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Bus model: accepts on valid&ready, answers with a done pulse 3 cycles later.
  initial begin : responder
    int   cnt;
    rsp_t cur;
    cnt = 0;
    cur = '{1'b0, 8'h00};
    forever begin
      @(negedge sys_clk);
      txn_done_i = 1'b0;
      txn_err_i  = 1'b0;
      if (!sys_rst_n) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            txn_done_i  = 1'b1;
            txn_err_i   = cur.err;
            txn_rdata_i = cur.rdata;
            done_cyc_q.push_back(cyc);
          end
        end
        if (txn_valid_o && txn_ready_i) begin
          obs_q.push_back('{txn_write_o, txn_reg_o, txn_wdata_o, cyc});
          cur = (rsp_q.size() > 0) ? rsp_q.pop_front() : '{1'b0, 8'h00};
          cnt = 3;
        end
      end
    end
  end

  function automatic logic [17:0] mk(input logic [1:0] op, input logic [7:0] r, input logic [7:0] v);
    return {op, r, v};
  endfunction

  function automatic txn_t ex(input logic wr, input logic [7:0] r, input logic [7:0] v);
    return '{wr, r, v, 0};
  endfunction

  task automatic load_table(input logic [17:0] e0, e1, e2, e3);
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
    exp_q.delete(); obs_q.delete(); rsp_q.delete(); done_cyc_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge sys_clk); start_i = 1'b1;
    @(negedge sys_clk); start_i = 1'b0;
  endtask

  task automatic wait_end(input int unsigned budget, output bit timed_out);
    timed_out = 1'b1;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (done_o || error_o) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({txn_valid_o, busy_o, done_o, error_o} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b required 0000", {txn_valid_o, busy_o, done_o, error_o});
    end
    checks++;
    if ({rom_addr_o, err_code_o, err_addr_o} !== 6'b0) begin
      errors++; $display("FAIL reset_regs got %b required 000000", {rom_addr_o, err_code_o, err_addr_o});
    end
    @(negedge sys_clk); sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy got %b required 0", busy_o); end
  endtask

  task automatic test_basic_writes();
    bit to;
    load_table(mk(2'b00, 8'h12, 8'h80), mk(2'b00, 8'h11, 8'h01), mk(2'b11, 0, 0), mk(2'b11, 0, 0));
    exp_q.push_back(ex(1, 8'h12, 8'h80));
    exp_q.push_back(ex(1, 8'h11, 8'h01));
    pulse_start();
    checks++;
    if ({busy_o, done_o, error_o} !== 3'b100) begin
      errors++; $display("FAIL basic_running got %b required 100", {busy_o, done_o, error_o});
    end
    wait_end(200, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got 1 required 0"); end
    checks++;
    if ({done_o, error_o, busy_o} !== 3'b100) begin
      errors++; $display("FAIL basic_end got %b required 100", {done_o, error_o, busy_o});
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_count got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      txn_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.wr !== e.wr || o.rg !== e.rg || o.dt !== e.dt) begin
        errors++; $display("FAIL basic_txn got %b/%h/%h required %b/%h/%h", o.wr, o.rg, o.dt, e.wr, e.rg, e.dt);
      end
    end
  endtask

  task automatic test_verify();
    bit to;
    for (int pass = 0; pass < 2; pass++) begin
      load_table(mk(2'b01, 8'h3A, 8'h04), mk(2'b11, 0, 0), mk(2'b11, 0, 0), mk(2'b11, 0, 0));
      for (int a = 0; a < ((pass == 0) ? 1 : 4); a++) begin
        exp_q.push_back(ex(1, 8'h3A, 8'h04));
        exp_q.push_back(ex(0, 8'h3A, 8'h00));
        rsp_q.push_back('{1'b0, 8'h00});
        rsp_q.push_back('{1'b0, (pass == 0) ? 8'h04 : 8'h05});
      end
      pulse_start();
      wait_end(400, to);
      checks++;
      if (to !== 1'b0) begin errors++; $display("FAIL verify%0d_timeout got 1 required 0", pass); end
      checks++;
      if (pass == 0 && {done_o, error_o} !== 2'b10) begin
        errors++; $display("FAIL verify_pass_end got %b required 10", {done_o, error_o});
      end else if (pass == 1 && {done_o, error_o, err_code_o, err_addr_o} !== 6'b01_10_00) begin
        errors++; $display("FAIL verify_fail_end got %b required 011000", {done_o, error_o, err_code_o, err_addr_o});
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL verify%0d_count got %0d required %0d", pass, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        txn_t e, o;
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++;
        if (o.wr !== e.wr || o.rg !== e.rg || (e.wr && o.dt !== e.dt)) begin
          errors++; $display("FAIL verify%0d_txn got %b/%h/%h required %b/%h/%h", pass, o.wr, o.rg, o.dt, e.wr, e.rg, e.dt);
        end
      end
    end
  endtask

  task automatic test_retry_nack();
    bit to;
    load_table(mk(2'b00, 8'h10, 8'hAA), mk(2'b00, 8'h20, 8'hBB), mk(2'b11, 0, 0), mk(2'b11, 0, 0));
    rsp_q.push_back('{1'b0, 8'h00});
    rsp_q.push_back('{1'b1, 8'h00});
    rsp_q.push_back('{1'b1, 8'h00});
    rsp_q.push_back('{1'b0, 8'h00});
    exp_q.push_back(ex(1, 8'h10, 8'hAA));
    for (int i = 0; i < 3; i++) exp_q.push_back(ex(1, 8'h20, 8'hBB));
    pulse_start();
    wait_end(300, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL retry_timeout got 1 required 0"); end
    checks++;
    if ({done_o, error_o} !== 2'b10) begin
      errors++; $display("FAIL retry_end got %b required 10", {done_o, error_o});
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL retry_count got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      txn_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.wr !== e.wr || o.rg !== e.rg || o.dt !== e.dt) begin
        errors++; $display("FAIL retry_txn got %b/%h/%h required %b/%h/%h", o.wr, o.rg, o.dt, e.wr, e.rg, e.dt);
      end
    end
  endtask

  // Gap = cycles from first write's done to second request; run 0 has no
  // delay entry, run 1 a zero delay, run 2 a 3-tick (30-cycle) delay.
  task automatic test_delay();
    bit to;
    int gap [3];
    for (int r = 0; r < 3; r++) begin
      if (r == 0)
        load_table(mk(2'b00, 8'h01, 8'h11), mk(2'b00, 8'h02, 8'h22), mk(2'b11, 0, 0), mk(2'b11, 0, 0));
      else
        load_table(mk(2'b00, 8'h01, 8'h11), mk(2'b10, 8'h00, (r == 1) ? 8'd0 : 8'd3),
                   mk(2'b00, 8'h02, 8'h22), mk(2'b11, 0, 0));
      pulse_start();
      wait_end(300, to);
      checks++;
      if (to !== 1'b0 || done_o !== 1'b1 || obs_q.size() != 2 || done_cyc_q.size() < 1) begin
        errors++; $display("FAIL delay%0d_run got done=%b txns=%0d required done=1 txns=2", r, done_o, obs_q.size());
        gap[r] = 0;
      end else begin
        checks++;
        if (obs_q[1].rg !== 8'h02 || obs_q[1].dt !== 8'h22) begin
          errors++; $display("FAIL delay%0d_txn got %h/%h required 02/22", r, obs_q[1].rg, obs_q[1].dt);
        end
        gap[r] = int'(obs_q[1].cy) - int'(done_cyc_q[0]);
      end
    end
    checks++;
    if (gap[1] > gap[0] + 2) begin
      errors++; $display("FAIL delay_zero_stall got %0d required <= %0d", gap[1], gap[0] + 2);
    end
    checks++;
    if (gap[2] - gap[1] < 28 || gap[2] - gap[1] > 32) begin
      errors++; $display("FAIL delay_three_ticks got %0d required 30+-2", gap[2] - gap[1]);
    end
  endtask

  task automatic test_overrun();
    bit to;
    load_table(mk(2'b00, 8'h40, 8'h00), mk(2'b00, 8'h41, 8'h01), mk(2'b00, 8'h42, 8'h02), mk(2'b00, 8'h43, 8'h03));
    pulse_start();
    wait_end(300, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL overrun_timeout got 1 required 0"); end
    checks++;
    if ({done_o, error_o, err_code_o, err_addr_o} !== 6'b01_11_11) begin
      errors++; $display("FAIL overrun_end got %b required 011111", {done_o, error_o, err_code_o, err_addr_o});
    end
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("FAIL overrun_count got %0d required 4", obs_q.size()); end
    load_table(mk(2'b00, 8'h55, 8'h66), mk(2'b11, 0, 0), mk(2'b11, 0, 0), mk(2'b11, 0, 0));
    pulse_start();
    checks++;
    if ({rom_addr_o, error_o, err_code_o} !== 5'b0) begin
      errors++; $display("FAIL restart_clear got %b required 00000", {rom_addr_o, error_o, err_code_o});
    end
    wait_end(200, to);
    checks++;
    if (to !== 1'b0 || done_o !== 1'b1 || obs_q.size() != 1) begin
      errors++; $display("FAIL restart_end got done=%b txns=%0d required done=1 txns=1", done_o, obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].rg !== 8'h55) begin errors++; $display("FAIL restart_txn got %h required 55", obs_q[0].rg); end
    end
  endtask

  task automatic test_reset_and_busy();
    bit to;
    load_table(mk(2'b00, 8'h77, 8'h01), mk(2'b11, 0, 0), mk(2'b11, 0, 0), mk(2'b11, 0, 0));
    txn_ready_i = 1'b0;
    pulse_start();
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (txn_valid_o) begin to = 1'b0; break; end
      @(negedge sys_clk);
    end
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL rst_valid_seen got 0 required 1"); end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({txn_valid_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL rst_async_drop got %b required 00", {txn_valid_o, busy_o});
    end
    @(negedge sys_clk); sys_rst_n = 1'b1; txn_ready_i = 1'b1;
    load_table(mk(2'b00, 8'hA1, 8'h01), mk(2'b00, 8'hA2, 8'h02), mk(2'b00, 8'hA3, 8'h03), mk(2'b11, 0, 0));
    exp_q.push_back(ex(1, 8'hA1, 8'h01));
    exp_q.push_back(ex(1, 8'hA2, 8'h02));
    exp_q.push_back(ex(1, 8'hA3, 8'h03));
    pulse_start();
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (rom_addr_o == 2'd1) begin to = 1'b0; break; end
      @(negedge sys_clk);
    end
    pulse_start();
    checks++;
    if (to !== 1'b0 || rom_addr_o !== 2'd1) begin
      errors++; $display("FAIL busy_start_addr got %0d required 1", rom_addr_o);
    end
    wait_end(300, to);
    checks++;
    if (to !== 1'b0 || done_o !== 1'b1 || obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL busy_end got done=%b txns=%0d required done=1 txns=%0d", done_o, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      txn_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.rg !== e.rg || o.dt !== e.dt) begin
        errors++; $display("FAIL busy_txn got %h/%h required %h/%h", o.rg, o.dt, e.rg, e.dt);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rom[i] = mk(2'b11, 8'h00, 8'h00);
    repeat (3) @(negedge sys_clk);
    test_reset();
    test_basic_writes();
    test_verify();
    test_retry_nack();
    test_delay();
    test_overrun();
    test_reset_and_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
